// File: rtl/updown_counter_if.sv
// Control and status bundle for updown_counter: the driver owns the count
// controls, the counter owns count/tc/wrap.
interface updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             sat;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up_dn, sat, load, load_val,
        input  count, tc, wrap
    );

    modport slave (
        input  en, up_dn, sat, load, load_val,
        output count, tc, wrap
    );
endinterface

// File: rtl/updown_counter.sv
// Up/down counter over 0..MAX with load, wrap-or-saturate boundary handling,
// a combinational terminal-count flag and a registered boundary-event pulse.
module updown_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             rstn,
    updown_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;

    // wrap_d flags a boundary hit in either sat mode; a saturating hold at
    // the boundary still counts as an event.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.load) begin
            count_d = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (count_q == MAX_V) begin
                    wrap_d  = 1'b1;
                    count_d = bus.sat ? MAX_V : '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    wrap_d  = 1'b1;
                    count_d = bus.sat ? '0 : MAX_V;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
    assign bus.tc    = bus.up_dn ? (count_q == MAX_V) : (count_q == '0);
endmodule

// File: tb/tb_updown_counter.sv
// Directed bench driving two counters (MAX=15 and MAX=9) with identical
// stimulus, checked every cycle against an arithmetic model plus literals.
module tb_updown_counter;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0, up_dn = 1'b0, sat = 1'b0, load = 1'b0;
    logic [3:0] lv = 4'd0;

    int checks = 0;
    int failures = 0;

    // model state
    int m15 = 0, m9 = 0;
    bit w15 = 1'b0, w9 = 1'b0;

    // literal expectation, checked on the next falling edge
    bit lit_en = 1'b0;
    int lit_sel = 0, lit_cnt = 0, lit_wrp = 0, lit_tc = 0;

    updown_counter_if #(.WIDTH(4)) b15 ();
    updown_counter_if #(.WIDTH(4)) b9 ();

    assign b15.en = en;  assign b15.up_dn = up_dn; assign b15.sat = sat;
    assign b15.load = load; assign b15.load_val = lv;
    assign b9.en = en;   assign b9.up_dn = up_dn;  assign b9.sat = sat;
    assign b9.load = load;  assign b9.load_val = lv;

    updown_counter #(.WIDTH(4), .MAX(15)) u15 (.clk(clk), .rstn(rstn), .bus(b15.slave));
    updown_counter #(.WIDTH(4), .MAX(9))  u9  (.clk(clk), .rstn(rstn), .bus(b9.slave));

    always #5 clk = ~clk;

    // Step the range 0..mx as a signed number line; leaving it is a boundary event.
    function automatic void nxt(input int c, input int mx, input bit e, input bit u,
                                input bit s, input bit l, input int v,
                                output int n, output bit w);
        int t;
        w = 1'b0;
        n = c;
        if (l) n = (v > mx) ? mx : v;
        else if (e) begin
            t = c + (u ? 1 : -1);
            if (t < 0 || t > mx) begin
                w = 1'b1;
                n = s ? c : (t + mx + 1) % (mx + 1);
            end else n = t;
        end
    endfunction

    always @(posedge clk or negedge rstn) begin : model
        int n;
        bit w;
        if (!rstn) begin
            m15 <= 0; w15 <= 1'b0; m9 <= 0; w9 <= 1'b0;
        end else begin
            nxt(m15, 15, en, up_dn, sat, load, int'(lv), n, w);
            m15 <= n; w15 <= w;
            nxt(m9, 9, en, up_dn, sat, load, int'(lv), n, w);
            m9 <= n; w9 <= w;
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        chk("cnt15", int'(b15.count), m15);
        chk("wrap15", int'(b15.wrap), int'(w15));
        chk("tc15", int'(b15.tc), int'(up_dn ? (m15 == 15) : (m15 == 0)));
        chk("cnt9", int'(b9.count), m9);
        chk("wrap9", int'(b9.wrap), int'(w9));
        chk("tc9", int'(b9.tc), int'(up_dn ? (m9 == 9) : (m9 == 0)));
        if (lit_en) begin
            if (lit_sel == 0) begin
                chk("lit_cnt15", int'(b15.count), lit_cnt);
                chk("lit_wrap15", int'(b15.wrap), lit_wrp);
                chk("lit_tc15", int'(b15.tc), lit_tc);
            end else begin
                chk("lit_cnt9", int'(b9.count), lit_cnt);
                chk("lit_wrap9", int'(b9.wrap), lit_wrp);
                chk("lit_tc9", int'(b9.tc), lit_tc);
            end
        end
    end

    task automatic drive(input bit e, input bit u, input bit s, input bit l, input int v);
        en = e; up_dn = u; sat = s; load = l; lv = 4'(v);
    endtask

    // inputs change just after the falling edge, so each step spans one rising edge
    task automatic step(input bit e, input bit u, input bit s, input bit l, input int v);
        @(negedge clk); #1;
        drive(e, u, s, l, v);
        @(posedge clk); #1;
        lit_en = 1'b0;
    endtask

    task automatic expect_lit(input int sel, input int c, input int w, input int t);
        lit_sel = sel; lit_cnt = c; lit_wrp = w; lit_tc = t; lit_en = 1'b1;
    endtask

    initial begin
        // held in reset: count 0, tc follows up_dn
        drive(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        expect_lit(0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        expect_lit(0, 0, 0, 0);
        @(negedge clk); #2;
        rstn = 1'b1;
        en = 1'b1;
        @(posedge clk); #1;
        lit_en = 1'b0;
        expect_lit(0, 1, 0, 0);

        // wrap up through 15 -> 0 (first edge already taken above)
        for (int i = 1; i < 17; i++) begin
            step(1, 1, 0, 0, 0);
            expect_lit(0, (i + 1) % 16, int'(i == 15), int'((i + 1) % 16 == 15));
        end

        // MAX=9 counting down, wrapping 0 -> 9
        step(0, 0, 0, 1, 0);
        expect_lit(1, 0, 0, 1);
        for (int i = 0; i < 11; i++) begin
            step(1, 0, 0, 0, 0);
            expect_lit(1, (19 - i) % 10, int'(i == 0 || i == 10), int'((19 - i) % 10 == 0));
        end

        // saturate at the top: wrap keeps pulsing while pinned at 15
        step(0, 1, 1, 1, 14);
        expect_lit(0, 14, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1, 0, 0);
            expect_lit(0, 15, int'(i > 0), 1);
        end

        // load beats en, and is clamped to MAX
        step(1, 1, 0, 1, 13);
        expect_lit(1, 9, 0, 1);
        step(0, 1, 0, 1, 9);
        expect_lit(1, 9, 0, 1);

        // direction flips take effect on the same edge
        step(0, 1, 0, 1, 5);
        expect_lit(0, 5, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, (i % 2) == 0, 0, 0, 0);
            expect_lit(0, ((i % 2) == 0) ? 6 : 5, 0, 0);
        end

        // saturate at the bottom, then hold clears wrap
        step(0, 0, 1, 1, 0);
        expect_lit(1, 0, 0, 1);
        step(1, 0, 1, 0, 0);
        expect_lit(1, 0, 1, 1);
        step(0, 0, 0, 0, 0);
        expect_lit(1, 0, 0, 1);
        step(0, 1, 0, 1, 3);
        expect_lit(0, 3, 0, 0);
        step(0, 0, 0, 0, 0);
        expect_lit(0, 3, 0, 0);

        // count to 7, reset between edges, pending load is discarded
        step(0, 1, 0, 1, 0);
        expect_lit(0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(1, 1, 0, 0, 0);
            expect_lit(0, i + 1, 0, 0);
        end
        #2;
        rstn = 1'b0;
        expect_lit(0, 0, 0, 0);
        step(1, 1, 0, 1, 3);
        expect_lit(0, 0, 0, 0);
        @(negedge clk); #2;
        lit_en = 1'b0;
        rstn = 1'b1;
        drive(1, 1, 0, 0, 0);
        @(posedge clk); #1;
        expect_lit(0, 1, 0, 0);

        step(0, 1, 0, 0, 0);
        expect_lit(0, 1, 0, 0);
        @(negedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
